// File: rtl/spi_pkg.sv
// Shared types for the back-to-back SPI master/slave pair.
package spi_pkg;

    localparam int DW_DEFAULT = 8;

    // bit1 = CPOL, bit0 = CPHA
    typedef enum logic [1:0] {
        MODE0 = 2'd0,
        MODE1 = 2'd1,
        MODE2 = 2'd2,
        MODE3 = 2'd3
    } spi_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

endpackage

// File: rtl/spi_master_core.sv
// SPI master engine: transfer FSM, SCLK divider and master shift register.
// Shift direction follows SPI_LSB_FIRST_EN (default MSB first).
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] masterin,
    input  logic          miso,
    output logic [DW-1:0] shreg,
    output spi_mode_t     cur_mode,
    output logic          load,
    output logic          sclk,
    output logic          mosi,
    output logic          ss_n,
    output logic          busy,
    output logic          done
);

    localparam int DIVW = $clog2(CLK_DIV);
    localparam int TW   = $clog2(2 * DW + 1);
    localparam logic [DIVW-1:0] DIV_END = DIVW'(CLK_DIV - 1);
    localparam logic [TW-1:0]   LAST    = TW'(2 * DW);

    state_t          state, state_n;
    logic [DIVW-1:0] div;
    logic [TW-1:0]   tcnt;
    logic            lead_evt, trail_evt, rx_bit, cpha;

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] s, input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, s[DW-1:1]};
`else
        return {s[DW-2:0], b};
`endif
    endfunction

    assign cpha = cur_mode[0];
`ifdef SPI_LSB_FIRST_EN
    assign mosi = shreg[0];
`else
    assign mosi = shreg[DW-1];
`endif
    assign ss_n = (state != XFER);
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_n = state;
        load    = 1'b0;
        case (state)
            IDLE: if (start) begin
                load    = 1'b1;
                state_n = XFER;
            end
            XFER:    if (tcnt == LAST) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Edge events act one cycle after the toggle so the master shifts/samples
    // on the same clk edge as the slave, whose edge detector lags by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_mode  <= MODE0;
            sclk      <= 1'b0;
            div       <= '0;
            tcnt      <= '0;
            shreg     <= '0;
            lead_evt  <= 1'b0;
            trail_evt <= 1'b0;
            rx_bit    <= 1'b0;
        end else begin
            state     <= state_n;
            lead_evt  <= 1'b0;
            trail_evt <= 1'b0;
            if (load) begin
                cur_mode <= spi_mode_t'(mode);
                shreg    <= masterin;
                sclk     <= mode[1];
                div      <= '0;
                tcnt     <= '0;
            end else if (state == XFER) begin
                if (tcnt != LAST) begin
                    if (div == DIV_END) begin
                        div       <= '0;
                        sclk      <= ~sclk;
                        tcnt      <= tcnt + 1'b1;
                        lead_evt  <= (sclk == cur_mode[1]);
                        trail_evt <= (sclk != cur_mode[1]);
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                if (lead_evt) begin
                    if (!cpha) rx_bit <= miso;
                    else if (tcnt != TW'(1)) shreg <= shift_in(shreg, rx_bit);
                end
                if (trail_evt) begin
                    if (!cpha) shreg <= shift_in(shreg, rx_bit);
                    else if (tcnt == LAST) shreg <= shift_in(shreg, miso);
                    else rx_bit <= miso;
                end
            end
        end
    end

endmodule

// File: rtl/spi_slave_core.sv
// SPI slave engine: SCLK edge detection from a registered copy, slave shift register.
// Shift direction follows SPI_LSB_FIRST_EN (default MSB first).
module spi_slave_core
    import spi_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [DW-1:0] slavein,
    input  spi_mode_t     cur_mode,
    input  logic          sclk,
    input  logic          ss_n,
    input  logic          mosi,
    output logic [DW-1:0] shreg,
    output logic          miso
);

    localparam int EW = $clog2(2 * DW);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

    logic          sclk_d, ss_d, rx_bit, cpha;
    logic          sclk_edge, lead;
    logic [EW-1:0] ecnt;

    function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] s, input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, s[DW-1:1]};
`else
        return {s[DW-2:0], b};
`endif
    endfunction

    assign cpha = cur_mode[0];
`ifdef SPI_LSB_FIRST_EN
    assign miso = shreg[0];
`else
    assign miso = shreg[DW-1];
`endif
    // ss_d masks the CPOL change that can coincide with ss_n falling.
    assign sclk_edge = !ss_n && !ss_d && (sclk != sclk_d);
    assign lead      = (sclk_d == cur_mode[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            sclk_d <= 1'b0;
            ss_d   <= 1'b1;
            ecnt   <= '0;
            rx_bit <= 1'b0;
        end else begin
            sclk_d <= sclk;
            ss_d   <= ss_n;
            if (load) begin
                shreg <= slavein;
                ecnt  <= '0;
            end else if (sclk_edge) begin
                ecnt <= ecnt + 1'b1;
                if (lead) begin
                    if (!cpha) rx_bit <= mosi;
                    else if (ecnt != '0) shreg <= shift_in(shreg, rx_bit);
                end else begin
                    if (!cpha) shreg <= shift_in(shreg, rx_bit);
                    else if (ecnt == LAST_EDGE) shreg <= shift_in(shreg, mosi);
                    else rx_bit <= mosi;
                end
            end
        end
    end

endmodule

// File: rtl/spi_ms_pair.sv
// SPI master and slave wired back-to-back; exchanges one DW-bit word per start.
// Optional SPI_LSB_FIRST_EN selects LSB-first transmission in both engines.
module spi_ms_pair
    import spi_pkg::*;
#(
    parameter int DW      = DW_DEFAULT,
    parameter int CLK_DIV = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] masterin,
    input  logic [DW-1:0] slavein,
    output logic [DW-1:0] masterout,
    output logic [DW-1:0] slaveout,
    output logic          sclk,
    output logic          mosi,
    output logic          miso,
    output logic          ss_n,
    output logic          busy,
    output logic          done
);

    spi_mode_t cur_mode;
    logic      load;

    spi_master_core #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) u_master (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .masterin (masterin),
        .miso     (miso),
        .shreg    (masterout),
        .cur_mode (cur_mode),
        .load     (load),
        .sclk     (sclk),
        .mosi     (mosi),
        .ss_n     (ss_n),
        .busy     (busy),
        .done     (done)
    );

    spi_slave_core #(
        .DW (DW)
    ) u_slave (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .slavein  (slavein),
        .cur_mode (cur_mode),
        .sclk     (sclk),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .shreg    (slaveout),
        .miso     (miso)
    );

endmodule

// File: tb/tb_spi_ms_pair.sv
// Bench for spi_ms_pair: vector table, corner sequences and random transfers.
`timescale 1ns/1ps
module tb_spi_ms_pair;
    import spi_pkg::*;

    localparam int DW       = 8;
    localparam int CLK_DIV  = 2;
    localparam int XFER_CYC = 2 * DW * CLK_DIV + 1;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [1:0]    mode;
    logic [DW-1:0] masterin, slavein, masterout, slaveout;
    logic          sclk, mosi, miso, ss_n, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    spi_ms_pair #(
        .DW      (DW),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .masterin  (masterin),
        .slavein   (slavein),
        .masterout (masterout),
        .slaveout  (slaveout),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .ss_n      (ss_n),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Index of the j-th transmitted bit of a word.
    function automatic int bit_idx(input int j);
`ifdef SPI_LSB_FIRST_EN
        return j;
`else
        return DW - 1 - j;
`endif
    endfunction

    // disturb: 0 none, 1 extra start + new data at cycle 5, 2 mode->3 mid-transfer, 3 reset at toggle 7
    task automatic run_xfer(input logic [1:0] m, input logic [DW-1:0] mi, input logic [DW-1:0] si,
                            input logic [DW-1:0] exp_mo, input logic [DW-1:0] exp_so,
                            input int disturb, input bit hold);
        logic cpol, cpha;
        int   t, j;
        cpol = m[1];
        cpha = m[0];
        mode = m; masterin = mi; slavein = si; start = 1'b1;
        @(posedge clk); #1;
        start = hold;
        chk("accept_ss_n", ss_n, 0);
        chk("accept_busy", busy, 1);
        chk("accept_sclk", sclk, cpol);
        chk("accept_mshreg", masterout, mi);
        chk("accept_sshreg", slaveout, si);
        if (!cpha) begin
            chk("cpha0_mosi_at_ss", mosi, mi[bit_idx(0)]);
            chk("cpha0_miso_at_ss", miso, si[bit_idx(0)]);
        end
        for (int k = 1; k <= XFER_CYC + 1; k++) begin
            @(posedge clk); #1;
            if (disturb == 3 && k == 7 * CLK_DIV) begin
                chk("rst_ss_n", ss_n, 1);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_mshreg", masterout, 0);
                chk("rst_sshreg", slaveout, 0);
                chk("rst_sclk", sclk, 0);
                chk("rst_mosi_miso", {mosi, miso}, 0);
                rst = 1'b0;
                break;
            end
            if (k < XFER_CYC) begin
                chk("xfer_done", done, 0);
                chk("xfer_busy", busy, 1);
                chk("xfer_ss_n", ss_n, 0);
                t = k / CLK_DIV;
                if (t > 2 * DW) t = 2 * DW;
                chk("xfer_sclk", sclk, cpol ^ t[0]);
                // line must hold the correct bit at each sampling edge
                if (!cpha && (k % (2 * CLK_DIV)) == CLK_DIV) begin
                    j = (k - CLK_DIV) / (2 * CLK_DIV);
                    chk("sample_mosi", mosi, mi[bit_idx(j)]);
                    chk("sample_miso", miso, si[bit_idx(j)]);
                end
                if (cpha && (k % (2 * CLK_DIV)) == 0) begin
                    j = k / (2 * CLK_DIV) - 1;
                    chk("sample_mosi", mosi, mi[bit_idx(j)]);
                    chk("sample_miso", miso, si[bit_idx(j)]);
                end
            end else if (k == XFER_CYC) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_ss_n", ss_n, 1);
                chk("done_sclk", sclk, cpol);
                chk("done_masterout", masterout, exp_mo);
                chk("done_slaveout", slaveout, exp_so);
            end else begin
                chk("post_done", done, 0);
                chk("post_busy", busy, 0);
                chk("post_ss_n", ss_n, 1);
                chk("post_sclk", sclk, cpol);
                chk("retain_masterout", masterout, exp_mo);
                chk("retain_slaveout", slaveout, exp_so);
            end
            if (disturb == 1 && k == 4) begin
                start = 1'b1; masterin = ~mi; slavein = ~si; mode = ~m;
            end
            if (disturb == 1 && k == 5) start = hold;
            if (disturb == 2 && k == 10) mode = 2'd3;
            if (disturb == 3 && k == 7 * CLK_DIV - 1) rst = 1'b1;
        end
    endtask

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] mi;
        logic [DW-1:0] si;
        logic [DW-1:0] exp_mo;
        logic [DW-1:0] exp_so;
        int            disturb;
        bit            hold;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{MODE0, 8'hA5, 8'h3C, 8'h3C, 8'hA5, 0, 1'b0};
        vecs[1]  = '{MODE1, 8'h81, 8'h7E, 8'h7E, 8'h81, 0, 1'b0};
        vecs[2]  = '{MODE2, 8'h81, 8'h7E, 8'h7E, 8'h81, 0, 1'b0};
        vecs[3]  = '{MODE3, 8'h81, 8'h7E, 8'h7E, 8'h81, 0, 1'b0};
        vecs[4]  = '{MODE0, 8'h5A, 8'hC3, 8'hC3, 8'h5A, 1, 1'b0};
        vecs[5]  = '{MODE0, 8'h0F, 8'hF0, 8'hF0, 8'h0F, 2, 1'b0};
        vecs[6]  = '{MODE3, 8'h12, 8'h34, 8'h34, 8'h12, 0, 1'b0};
        vecs[7]  = '{MODE1, 8'hC5, 8'h5C, 8'h00, 8'h00, 3, 1'b0};
        vecs[8]  = '{MODE1, 8'hC5, 8'h5C, 8'h5C, 8'hC5, 0, 1'b0};
        vecs[9]  = '{MODE0, 8'hFF, 8'h00, 8'h00, 8'hFF, 0, 1'b1};
        vecs[10] = '{MODE0, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 1'b1};
        vecs[11] = '{MODE0, 8'hFF, 8'h00, 8'h00, 8'hFF, 0, 1'b1};
        vecs[12] = '{MODE0, 8'h00, 8'hFF, 8'hFF, 8'h00, 0, 1'b0};

        rst = 1'b1; start = 1'b0; mode = 2'd0; masterin = 8'hC9; slavein = 8'h96;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_masterout", masterout, 0);
        chk("reset_slaveout", slaveout, 0);
        chk("reset_sclk", sclk, 0);
        chk("reset_ss_n", ss_n, 1);
        chk("reset_mosi", mosi, 0);
        chk("reset_miso", miso, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_spurious_busy", busy, 0);

        for (int i = 0; i < 13; i++)
            run_xfer(vecs[i].mode, vecs[i].mi, vecs[i].si, vecs[i].exp_mo, vecs[i].exp_so,
                     vecs[i].disturb, vecs[i].hold);

        // Random exchanges: the reference is the word swap plus per-edge bit order.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]    rm;
            logic [DW-1:0] rmi, rsi;
            int            rd;
            rm  = 2'($urandom_range(0, 3));
            rmi = DW'($urandom);
            rsi = DW'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            run_xfer(rm, rmi, rsi, rsi, rmi, rd, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ms_pair.md
Name: spi_ms_pair

Overview:
- Self-contained full-duplex SPI link: one SPI master engine and one SPI slave engine wired back-to-back on internal SCLK/MOSI/MISO/SS lines.
- On a start pulse, exchanges one word: master's word goes to the slave and the slave's word goes to the master, in any of the four CPOL/CPHA modes.
- Used as the verification target for the SPI environment. Both shift registers and the bus lines are exposed for scoreboarding.

Parameters:
- DW, 8, word width in bits (≥2).
- CLK_DIV, 2, clk cycles per SCLK half-period (≥2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin transfer; sampled only in IDLE.
- mode  in  2  SPI mode; bit1=CPOL, bit0=CPHA; latched on accepted start.
- masterin  in  DW  word loaded into master shift register at start.
- slavein  in  DW  word loaded into slave shift register at start.
- masterout  out  DW  live master shift register.
- slaveout  out  DW  live slave shift register.
- sclk  out  1  SPI clock.
- mosi  out  1  master→slave line.
- miso  out  1  slave→master line.
- ss_n  out  1  active-low slave select.
- busy  out  1  high from accept until done.
- done  out  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset values: masterout=0, slaveout=0, latched mode=0, sclk=0, ss_n=1, mosi=0, miso=0, busy=0, done=0, state=IDLE.
- Master FSM states: IDLE, XFER, DONE.
- IDLE:
  - ss_n=1; sclk=latched CPOL.
  - When start=1 at a rising edge, on that same edge: latch mode, load master shreg←masterin and slave shreg←slavein, ss_n←0, busy←1, go to XFER.
- XFER:
  - sclk toggles every CLK_DIV clk cycles, 2·DW toggles total. Odd-numbered toggles are leading edges, even-numbered toggles are trailing edges.
  - MSB first: mosi=master shreg[DW-1], miso=slave shreg[DW-1].
  - CPHA=0: data valid as soon as ss_n falls. Both sides sample on leading edges and shift (left, sampled bit into LSB) on trailing edges.
  - CPHA=1: both sides shift out on leading edges and sample on trailing edges. The final trailing edge completes the last shift.
  - After the 2·DW-th toggle, sclk rests at CPOL; go to DONE.
- Timing: done asserts exactly 2·DW·CLK_DIV+1 clk cycles after the start-accept edge.
- DONE (one cycle): ss_n=1, done=1; busy falls on the next edge and the FSM returns to IDLE.
  - At done: masterout = original slavein, slaveout = original masterin.
- Slave:
  - Same clk domain; detects sclk edges from a registered copy of sclk, gated by ss_n=0. The detection lag of one cycle is absorbed by CLK_DIV≥2.
  - Slave shreg holds its value while ss_n=1.
- Boundary conditions:
  - start while busy: ignored.
  - mode or masterin/slavein changes mid-transfer: no effect.
  - start asserted in DONE: ignored. Start held high: a new transfer is accepted on the first IDLE cycle.
  - rst mid-transfer: immediate return to reset values on that edge; no done pulse.
  - Shift registers retain the final values in IDLE until the next accepted start.

Optional Feature:
- Macro SPI_LSB_FIRST_EN.
- Defined: both engines transmit LSB first. mosi/miso = shreg[0]; shreg shifts right with sampled bit into MSB. Exchange result is identical: masterout=slavein, slaveout=masterin.
- Undefined: MSB first as above.

Decomposition:
- Package spi_pkg holds:
  - typedef spi_mode_t (2-bit; MODE0..MODE3 constants);
  - typedef state_t {IDLE, XFER, DONE};
  - DW default constant.
- Natural sub-modules:
  - spi_master_core: FSM, sclk divider, master shreg;
  - spi_slave_core: edge detect, slave shreg.
- spi_ms_pair instantiates both and wires the bus.

Test Plan:
- Mode 0, masterin=8'hA5, slavein=8'h3C, one start pulse → done at 33 cycles after accept; masterout=8'h3C, slaveout=8'hA5, ss_n high again, sclk=0.
- Modes 1,2,3 with masterin=8'h81, slavein=8'h7E → same swap each mode; idle sclk = CPOL; first mosi change/sample on the correct edge per CPHA.
- start pulsed at cycle 5 of an active transfer with different data → ignored; result unchanged; single done pulse.
- rst asserted at toggle 7 of a transfer → next cycle ss_n=1, busy=0, shregs=0, no done; next start completes normally.
- Back-to-back: start held high, masterin=8'hFF/8'h00 alternating → consecutive transfers each separated by the DONE cycle, all swaps correct.
- mode changed mid-transfer from 0 to 3 → transfer completes in mode 0; next transfer uses mode 3.
